// File: rtl/fetch_queue.sv
// Fetch stage with a small prefetch FIFO feeding the decode register of the ARM pipeline.
// One instruction-memory request is in flight at a time; redirects squash queued and in-flight work.
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ImemReqF,
    output logic [31:0] ImemAddrF,
    input  logic        ImemAckF,
    input  logic [31:0] ImemRDataF,
    input  logic        PCWrPendingF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenD,
    input  logic [31:0] BranchTargetD,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        InstrValidD
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]   pcF;
    logic [31:0]   pcReq;
    logic          outstanding;
    logic          drop;
    logic [CW-1:0] count;
    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;
    logic [31:0]   instrMem [DEPTH];
    logic [31:0]   pcMem    [DEPTH];

    logic          redirect;
    logic [31:0]   target;
    logic          ackValid;
    logic          push;
    logic          pop;
    logic          fifoEmpty;

    // Writeback PC writes win over an early branch; a stalled decode cannot branch.
    assign redirect  = PCSrcW | (BranchTakenD & ~StallD);
    assign target    = PCSrcW ? ResultW : BranchTargetD;
    assign fifoEmpty = (count == '0);

    assign ImemReqF  = ~outstanding & ~PCWrPendingF & ~redirect & (count < FULL_COUNT);
    assign ImemAddrF = pcF;

    assign ackValid  = ImemAckF & outstanding;
    assign push      = ackValid & ~drop & ~redirect;
    assign pop       = ~redirect & ~StallD & ~FlushD & ~fifoEmpty;

    // Fetch PC and the single in-flight request; a redirect with the request still
    // outstanding marks its eventual response as stale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcF         <= RESET_PC;
            pcReq       <= RESET_PC;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else begin
            if (redirect) begin
                pcF <= target;
            end else if (ImemReqF) begin
                pcF   <= pcF + 32'd4;
                pcReq <= pcF;
            end

            if (ImemReqF) begin
                outstanding <= 1'b1;
            end else if (ackValid) begin
                outstanding <= 1'b0;
            end

            if (redirect) begin
                drop <= outstanding & ~ImemAckF;
            end else if (ackValid) begin
                drop <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else if (redirect) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                tailPtr <= tailPtr + PW'(1);
            end
            if (pop) begin
                headPtr <= headPtr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instrMem[tailPtr] <= ImemRDataF;
            pcMem[tailPtr]    <= pcReq;
        end
    end

    // Decode register: redirect beats stall, stall beats flush, otherwise pop or bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            InstrD      <= NOP_INSTR;
            PCPlus8D    <= RESET_PC + 32'd8;
            InstrValidD <= 1'b0;
        end else if (redirect) begin
            InstrD      <= NOP_INSTR;
            InstrValidD <= 1'b0;
        end else if (StallD) begin
            InstrD      <= InstrD;
            InstrValidD <= InstrValidD;
        end else if (pop) begin
            InstrD      <= instrMem[headPtr];
            PCPlus8D    <= pcMem[headPtr] + 32'd8;
            InstrValidD <= 1'b1;
        end else begin
            InstrD      <= NOP_INSTR;
            InstrValidD <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a queue-based reference model plus a variable-latency memory.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ImemReqF;
    logic [31:0] ImemAddrF;
    logic        ImemAckF;
    logic [31:0] ImemRDataF;
    logic        PCWrPendingF;
    logic        StallD;
    logic        FlushD;
    logic        BranchTakenD;
    logic [31:0] BranchTargetD;
    logic        PCSrcW;
    logic [31:0] ResultW;
    logic [31:0] InstrD;
    logic [31:0] PCPlus8D;
    logic        InstrValidD;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset),
        .ImemReqF(ImemReqF), .ImemAddrF(ImemAddrF), .ImemAckF(ImemAckF), .ImemRDataF(ImemRDataF),
        .PCWrPendingF(PCWrPendingF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenD(BranchTakenD), .BranchTargetD(BranchTargetD),
        .PCSrcW(PCSrcW), .ResultW(ResultW),
        .InstrD(InstrD), .PCPlus8D(PCPlus8D), .InstrValidD(InstrValidD)
    );

    int nVec = 0;
    int nErr = 0;

    logic [31:0] mPcF, mReqPc, mInstrD, mPc8D;
    logic        mOut, mDrop, mValid;
    logic [63:0] mQ[$];

    logic        memPend, memFire, nopWords;
    logic [31:0] memAddr;
    int          memWait, memMinLat, memMaxLat;

    wire [97:0] dutVec = {ImemReqF, ImemAddrF, InstrValidD, InstrD, InstrValidD ? PCPlus8D : 32'h0};

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return nopWords ? NOP : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction

    task automatic modelReset();
        mPcF    = RESET_PC;
        mReqPc  = RESET_PC;
        mOut    = 1'b0;
        mDrop   = 1'b0;
        mQ.delete();
        mInstrD = NOP;
        mPc8D   = RESET_PC + 32'd8;
        mValid  = 1'b0;
    endtask

    function automatic logic expReq();
        logic redir;
        redir = PCSrcW | (BranchTakenD & ~StallD);
        return !mOut && !PCWrPendingF && !redir && (mQ.size() < DEPTH);
    endfunction

    function automatic logic [97:0] expVec();
        return {expReq(), mPcF, mValid, mInstrD, mValid ? mPc8D : 32'h0};
    endfunction

    // Reference behaviour for one clock edge, using the inputs held during the cycle.
    task automatic modelUpdate(input logic req);
        logic        redir;
        logic [63:0] e;
        if (!reset) begin
            modelReset();
            return;
        end
        redir = PCSrcW | (BranchTakenD & ~StallD);
        if (redir) begin
            mInstrD = NOP;
            mValid  = 1'b0;
            mQ.delete();
            mDrop   = mOut && !ImemAckF;
            if (ImemAckF) mOut = 1'b0;
            mPcF    = PCSrcW ? ResultW : BranchTargetD;
            return;
        end
        if (!StallD) begin
            if (!FlushD && mQ.size() > 0) begin
                e       = mQ.pop_front();
                mInstrD = e[63:32];
                mPc8D   = e[31:0] + 32'd8;
                mValid  = 1'b1;
            end else begin
                mInstrD = NOP;
                mValid  = 1'b0;
            end
        end
        if (ImemAckF && mOut) begin
            if (mDrop) mDrop = 1'b0;
            else mQ.push_back({ImemRDataF, mReqPc});
            mOut = 1'b0;
        end
        if (req) begin
            mReqPc = mPcF;
            mPcF   = mPcF + 32'd4;
            mOut   = 1'b1;
        end
    endtask

    task automatic memStep(input logic req, input logic [31:0] addr);
        if (!reset) begin
            memPend = 1'b0;
            return;
        end
        if (memFire) memPend = 1'b0;
        if (req) begin
            memPend = 1'b1;
            memAddr = addr;
            memWait = int'($urandom_range(memMaxLat, memMinLat)) - 1;
        end else if (memPend && memWait > 0) begin
            memWait--;
        end
    endtask

    task automatic driveMem();
        memFire    = memPend && (memWait == 0);
        ImemAckF   = memFire;
        ImemRDataF = memFire ? memWord(memAddr) : $urandom();
    endtask

    task automatic advance();
        logic        reqNow;
        logic [31:0] addrNow;
        @(posedge clk);
        reqNow  = expReq();
        addrNow = mPcF;
        modelUpdate(reqNow);
        memStep(reqNow, addrNow);
        #1;
        driveMem();
    endtask

    task automatic clearCtrl();
        PCWrPendingF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        BranchTakenD = 1'b0; BranchTargetD = 32'h0; PCSrcW = 1'b0; ResultW = 32'h0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nVec++;
            if ({InstrValidD, InstrD, PCPlus8D, ImemAddrF} !== {1'b0, NOP, RESET_PC + 32'd8, RESET_PC}) begin
                nErr++;
                $display("[TB] FAIL reset_state got v=%b instr=%h pc8=%h addr=%h", InstrValidD, InstrD, PCPlus8D, ImemAddrF);
            end
            advance();
        end
        reset = 1'b1;
    endtask

    task automatic test_stream();
        int firstValid = -1;
        nopWords = 1'b1; memMinLat = 1; memMaxLat = 1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            nVec++;
            if (dutVec !== expVec()) begin
                nErr++;
                $display("[TB] FAIL stream cyc=%0d got=%h exp=%h", i, dutVec, expVec());
            end
            if (i < 10 && i % 2 == 0) begin
                nVec++;
                if ({ImemReqF, ImemAddrF} !== {1'b1, 32'(i * 2)}) begin
                    nErr++;
                    $display("[TB] FAIL stream_addr cyc=%0d got req=%b addr=%h exp req=1 addr=%h", i, ImemReqF, ImemAddrF, 32'(i * 2));
                end
            end
            if (InstrValidD && firstValid < 0) firstValid = i;
            advance();
        end
        nVec++;
        if (firstValid != 3) begin
            nErr++;
            $display("[TB] FAIL first_valid_latency got %0d exp 3", firstValid);
        end
        nopWords = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0] held;
        logic [31:0] lastPc8;
        logic        haveLast = 1'b0;
        memMinLat = 1; memMaxLat = 1;
        StallD = 1'b1;
        held = mInstrD;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            nVec++;
            if (dutVec !== expVec()) begin
                nErr++;
                $display("[TB] FAIL stall cyc=%0d got=%h exp=%h", i, dutVec, expVec());
            end
            nVec++;
            if (InstrD !== held) begin
                nErr++;
                $display("[TB] FAIL stall_hold cyc=%0d got instr=%h exp %h", i, InstrD, held);
            end
            if (i >= 10) begin
                nVec++;
                if (ImemReqF !== 1'b0) begin
                    nErr++;
                    $display("[TB] FAIL stall_full_noreq cyc=%0d got req=%b exp 0", i, ImemReqF);
                end
            end
            advance();
        end
        StallD = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            nVec++;
            if (dutVec !== expVec()) begin
                nErr++;
                $display("[TB] FAIL drain cyc=%0d got=%h exp=%h", i, dutVec, expVec());
            end
            if (InstrValidD) begin
                if (haveLast) begin
                    nVec++;
                    if (PCPlus8D !== lastPc8 + 32'd4) begin
                        nErr++;
                        $display("[TB] FAIL drain_order cyc=%0d got pc8=%h exp %h", i, PCPlus8D, lastPc8 + 32'd4);
                    end
                end
                lastPc8  = PCPlus8D;
                haveLast = 1'b1;
            end
            advance();
        end
    endtask

    task automatic test_branch();
        logic found = 1'b0;
        logic seen  = 1'b0;
        memMinLat = 3; memMaxLat = 3;
        for (int i = 0; i < 20; i++) begin
            if (mOut && !ImemAckF) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            nVec++;
            if (dutVec !== expVec()) begin
                nErr++;
                $display("[TB] FAIL branch_pre cyc=%0d got=%h exp=%h", i, dutVec, expVec());
            end
            advance();
        end
        nVec++;
        if (!found) begin
            nErr++;
            $display("[TB] FAIL branch_setup got no outstanding window exp one within 20 cycles");
        end
        BranchTakenD = 1'b1; BranchTargetD = 32'h100;
        @(negedge clk);
        nVec++;
        if (dutVec !== expVec() || ImemReqF !== 1'b0) begin
            nErr++;
            $display("[TB] FAIL branch_cycle got=%h exp=%h", dutVec, expVec());
        end
        advance();
        BranchTakenD = 1'b0;
        @(negedge clk);
        nVec++;
        if (InstrValidD !== 1'b0 || dutVec !== expVec()) begin
            nErr++;
            $display("[TB] FAIL branch_bubble got v=%b vec=%h exp v=0 vec=%h", InstrValidD, dutVec, expVec());
        end
        advance();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            nVec++;
            if (dutVec !== expVec()) begin
                nErr++;
                $display("[TB] FAIL branch_post cyc=%0d got=%h exp=%h", i, dutVec, expVec());
            end
            if (ImemReqF && !seen) begin
                seen = 1'b1;
                nVec++;
                if (ImemAddrF !== 32'h100) begin
                    nErr++;
                    $display("[TB] FAIL branch_target got addr=%h exp 00000100", ImemAddrF);
                end
            end
            advance();
        end
        nVec++;
        if (!seen) begin
            nErr++;
            $display("[TB] FAIL branch_refetch got no request exp request at 00000100");
        end
    endtask

    task automatic test_double_redirect();
        memMinLat = 1; memMaxLat = 3;
        PCSrcW = 1'b1; ResultW = 32'h40; BranchTakenD = 1'b1; BranchTargetD = 32'h80;
        @(negedge clk);
        nVec++;
        if (dutVec !== expVec()) begin
            nErr++;
            $display("[TB] FAIL double_cycle got=%h exp=%h", dutVec, expVec());
        end
        advance();
        clearCtrl();
        @(negedge clk);
        nVec++;
        if (ImemAddrF !== 32'h40 || InstrValidD !== 1'b0 || dutVec !== expVec()) begin
            nErr++;
            $display("[TB] FAIL double_target got addr=%h v=%b exp addr=00000040 v=0", ImemAddrF, InstrValidD);
        end
        advance();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nVec++;
            if (dutVec !== expVec()) begin
                nErr++;
                $display("[TB] FAIL double_post cyc=%0d got=%h exp=%h", i, dutVec, expVec());
            end
            advance();
        end
    endtask

    task automatic test_branch_while_stall();
        logic [31:0] capAddr, capInstr;
        logic        capValid;
        memMinLat = 1; memMaxLat = 1;
        StallD = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            nVec++;
            if (dutVec !== expVec()) begin
                nErr++;
                $display("[TB] FAIL bstall_fill cyc=%0d got=%h exp=%h", i, dutVec, expVec());
            end
            advance();
        end
        capAddr = mPcF; capInstr = mInstrD; capValid = mValid;
        BranchTakenD = 1'b1; BranchTargetD = 32'h200;
        @(negedge clk);
        nVec++;
        if (dutVec !== expVec() || ImemReqF !== 1'b0) begin
            nErr++;
            $display("[TB] FAIL bstall_cycle got=%h exp=%h", dutVec, expVec());
        end
        advance();
        BranchTakenD = 1'b0;
        @(negedge clk);
        nVec++;
        if ({ImemAddrF, InstrD, InstrValidD} !== {capAddr, capInstr, capValid}) begin
            nErr++;
            $display("[TB] FAIL bstall_ignored got addr=%h instr=%h v=%b exp addr=%h instr=%h v=%b",
                     ImemAddrF, InstrD, InstrValidD, capAddr, capInstr, capValid);
        end
        advance();
        StallD = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nVec++;
            if (dutVec !== expVec()) begin
                nErr++;
                $display("[TB] FAIL bstall_drain cyc=%0d got=%h exp=%h", i, dutVec, expVec());
            end
            advance();
        end
    endtask

    task automatic test_pcwr_pending();
        logic found = 1'b0;
        int   nValid = 0;
        memMinLat = 1; memMaxLat = 1;
        StallD = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (mQ.size() >= 2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            nVec++;
            if (dutVec !== expVec()) begin
                nErr++;
                $display("[TB] FAIL pcwr_fill cyc=%0d got=%h exp=%h", i, dutVec, expVec());
            end
            advance();
        end
        nVec++;
        if (!found) begin
            nErr++;
            $display("[TB] FAIL pcwr_setup got fewer than 2 queued exp 2 within 12 cycles");
        end
        StallD = 1'b0;
        for (int c = 0; c < 5; c++) begin
            PCWrPendingF = (c < 3);
            @(negedge clk);
            nVec++;
            if (dutVec !== expVec()) begin
                nErr++;
                $display("[TB] FAIL pcwr cyc=%0d got=%h exp=%h", c, dutVec, expVec());
            end
            if (c < 3) begin
                nVec++;
                if (ImemReqF !== 1'b0) begin
                    nErr++;
                    $display("[TB] FAIL pcwr_block cyc=%0d got req=%b exp 0", c, ImemReqF);
                end
            end
            if ((c == 1 || c == 2) && InstrValidD === 1'b1) nValid++;
            advance();
        end
        nVec++;
        if (nValid != 2) begin
            nErr++;
            $display("[TB] FAIL pcwr_drain got %0d valid exp 2", nValid);
        end
    endtask

    task automatic test_random();
        memMinLat = 1; memMaxLat = 3;
        for (int i = 0; i < 400; i++) begin
            StallD        = ($urandom_range(0, 3) == 0);
            FlushD        = ($urandom_range(0, 9) == 0);
            BranchTakenD  = ($urandom_range(0, 11) == 0);
            BranchTargetD = 32'($urandom_range(0, 1023)) << 2;
            PCSrcW        = ($urandom_range(0, 24) == 0);
            ResultW       = 32'($urandom_range(0, 1023)) << 2;
            PCWrPendingF  = ($urandom_range(0, 6) == 0);
            @(negedge clk);
            nVec++;
            if (dutVec !== expVec()) begin
                nErr++;
                $display("[TB] FAIL random cyc=%0d got=%h exp=%h", i, dutVec, expVec());
            end
            advance();
        end
        clearCtrl();
    endtask

    task automatic test_reset_mid();
        memMinLat = 3; memMaxLat = 3;
        for (int i = 0; i < 20; i++) begin
            if (mOut && !ImemAckF) break;
            @(negedge clk);
            nVec++;
            if (dutVec !== expVec()) begin
                nErr++;
                $display("[TB] FAIL rmid_pre cyc=%0d got=%h exp=%h", i, dutVec, expVec());
            end
            advance();
        end
        reset = 1'b0;
        modelReset();
        @(negedge clk);
        nVec++;
        if ({InstrValidD, InstrD, PCPlus8D, ImemAddrF} !== {1'b0, NOP, RESET_PC + 32'd8, RESET_PC}) begin
            nErr++;
            $display("[TB] FAIL rmid_state got v=%b instr=%h pc8=%h addr=%h", InstrValidD, InstrD, PCPlus8D, ImemAddrF);
        end
        advance();
        reset      = 1'b1;
        ImemAckF   = 1'b1;
        ImemRDataF = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nVec++;
            if (dutVec !== expVec() || InstrD === 32'hDEAD_BEEF) begin
                nErr++;
                $display("[TB] FAIL rmid_post cyc=%0d got=%h exp=%h", i, dutVec, expVec());
            end
            advance();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0;
        clearCtrl();
        nopWords = 1'b0; memPend = 1'b0; memWait = 0; memAddr = 32'h0;
        memMinLat = 1; memMaxLat = 1;
        modelReset();
        driveMem();
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_double_redirect();
        test_branch_while_stall();
        test_pcwr_pending();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
